// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor and the speculative execution stage:
// PC geometry, 2-bit direction counter encodings and the saturating counter step.
package bp_pkg;

    localparam int PC_W     = 8;
    localparam int IDX_BITS = 3;
    localparam int STAT_W   = 16;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    function automatic logic [1:0] sat2_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        result = ctr;
        if (taken) begin
            if (ctr != STRONG_T) begin
                result = ctr + 2'b01;
            end
        end else begin
            if (ctr != STRONG_NT) begin
                result = ctr - 2'b01;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bp_btb_table.sv
// Direct-mapped BTB storage: valid/tag/target/counter arrays with one combinational
// read port and one synchronous training write port (hit update or allocate on taken miss).
module bp_btb_table #(
    parameter int IDX_BITS = bp_pkg::IDX_BITS,
    parameter int PC_W     = bp_pkg::PC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IDX_BITS-1:0]      rd_idx,
    output logic                     rd_valid,
    output logic [PC_W-IDX_BITS-1:0] rd_tag,
    output logic [PC_W-1:0]          rd_target,
    output logic                     rd_dir,
    input  logic                     wr_en,
    input  logic [IDX_BITS-1:0]      wr_idx,
    input  logic [PC_W-IDX_BITS-1:0] wr_tag,
    input  logic                     wr_taken,
    input  logic [PC_W-1:0]          wr_target
);
    import bp_pkg::*;

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = PC_W - IDX_BITS;

    logic             valid_reg  [ENTRIES];
    logic [TAG_W-1:0] tag_reg    [ENTRIES];
    logic [PC_W-1:0]  target_reg [ENTRIES];
    logic [1:0]       ctr_reg    [ENTRIES];

    logic [ENTRIES-1:0] wr_sel;
    logic [ENTRIES-1:0] wr_hit;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_decode
            assign wr_sel[gi] = wr_en && (wr_idx == IDX_BITS'(gi));
            assign wr_hit[gi] = valid_reg[gi] && (tag_reg[gi] == wr_tag);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (rst) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                ctr_reg[i]    <= WEAK_NT;
            end else if (wr_sel[i]) begin
                if (wr_hit[i]) begin
                    ctr_reg[i] <= sat2_update(ctr_reg[i], wr_taken);
                    if (wr_taken) begin
                        target_reg[i] <= wr_target;
                    end
                end else if (wr_taken) begin
                    // A taken miss evicts whatever aliased into this slot.
                    valid_reg[i]  <= 1'b1;
                    tag_reg[i]    <= wr_tag;
                    target_reg[i] <= wr_target;
                    ctr_reg[i]    <= WEAK_T;
                end
            end
        end
    end

    assign rd_valid  = valid_reg[rd_idx];
    assign rd_tag    = tag_reg[rd_idx];
    assign rd_target = target_reg[rd_idx];
    assign rd_dir    = ctr_reg[rd_idx][1];

endmodule

// File: rtl/branch_predictor.sv
// Front-end branch predictor: zero-latency BTB lookup, training from resolved branches,
// registered mispredict pulse and saturating resolution/misprediction statistics.
module branch_predictor #(
    parameter int IDX_BITS = bp_pkg::IDX_BITS,
    parameter int PC_W     = bp_pkg::PC_W,
    parameter int STAT_W   = bp_pkg::STAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_valid,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              branch_prediction,
    output logic [PC_W-1:0]   predicted_target,
    output logic              btb_hit,
    input  logic              resolve_valid,
    input  logic [PC_W-1:0]   resolve_pc,
    input  logic              resolve_taken,
    input  logic [PC_W-1:0]   resolve_target,
    input  logic              resolve_pred_taken,
    input  logic [PC_W-1:0]   resolve_pred_target,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_resolved,
    output logic [STAT_W-1:0] stat_mispredicted
);
    import bp_pkg::*;

    localparam int TAG_W = PC_W - IDX_BITS;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [PC_W-1:0]  rd_target;
    logic             rd_dir;
    logic             lookup_hit;

    logic             mispredict_reg;
    logic             mispredict_next;
    logic [STAT_W-1:0] stat_resolved_reg;
    logic [STAT_W-1:0] stat_resolved_next;
    logic [STAT_W-1:0] stat_mispredicted_reg;
    logic [STAT_W-1:0] stat_mispredicted_next;
    logic             resolve_wrong;

    bp_btb_table #(
        .IDX_BITS (IDX_BITS),
        .PC_W     (PC_W)
    ) u_btb_table (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (lookup_pc[IDX_BITS-1:0]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .rd_dir    (rd_dir),
        .wr_en     (resolve_valid),
        .wr_idx    (resolve_pc[IDX_BITS-1:0]),
        .wr_tag    (resolve_pc[PC_W-1:IDX_BITS]),
        .wr_taken  (resolve_taken),
        .wr_target (resolve_target)
    );

    // Table contents seen here are pre-update for any same-cycle resolve.
    assign lookup_hit        = rd_valid && (rd_tag == lookup_pc[PC_W-1:IDX_BITS]);
    assign btb_hit           = lookup_valid && lookup_hit;
    assign branch_prediction = btb_hit && rd_dir;
    assign predicted_target  = branch_prediction ? rd_target : (lookup_pc + PC_W'(1));

    assign resolve_wrong = (resolve_taken != resolve_pred_taken) ||
                           (resolve_taken && (resolve_target != resolve_pred_target));

    always_comb begin
        mispredict_next        = resolve_valid && resolve_wrong;
        stat_resolved_next     = stat_resolved_reg;
        stat_mispredicted_next = stat_mispredicted_reg;
        if (resolve_valid && (stat_resolved_reg != {STAT_W{1'b1}})) begin
            stat_resolved_next = stat_resolved_reg + STAT_W'(1);
        end
        if (mispredict_next && (stat_mispredicted_reg != {STAT_W{1'b1}})) begin
            stat_mispredicted_next = stat_mispredicted_reg + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_reg        <= 1'b0;
            stat_resolved_reg     <= '0;
            stat_mispredicted_reg <= '0;
        end else begin
            mispredict_reg        <= mispredict_next;
            stat_resolved_reg     <= stat_resolved_next;
            stat_mispredicted_reg <= stat_mispredicted_next;
        end
    end

    assign mispredict        = mispredict_reg;
    assign stat_resolved     = stat_resolved_reg;
    assign stat_mispredicted = stat_mispredicted_reg;

endmodule
